ieeedrv_sd_arb: RTL and testbench

//  Arbitrates NREQ independent SD block-request channels onto one MiSTer hps_io SD port.

---
 rtl/ieeedrv_sd_arb_if.sv | 32 +++
 rtl/ieeedrv_sd_arb.sv | 129 ++++++++++++
 tb/tb_ieeedrv_sd_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ieeedrv_sd_arb_if.sv
// hps_io SD block-request port shared by the IEEE drive subdrives.
// The master modport is the arbiter side; the slave modport is the hps_io side.
interface ieeedrv_sd_arb_if;
  localparam int unsigned LBA_W  = 32;
  localparam int unsigned BLK_W  = 6;
  localparam int unsigned DATA_W = 8;

  logic [LBA_W-1:0]  sd_lba;
  logic [BLK_W-1:0]  sd_blk_cnt;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [DATA_W-1:0] sd_buff_din;

  modport master (
    output sd_lba,
    output sd_blk_cnt,
    output sd_rd,
    output sd_wr,
    output sd_buff_din,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_blk_cnt,
    input  sd_rd,
    input  sd_wr,
    input  sd_buff_din,
    output sd_ack
  );
endinterface

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter folding NREQ SD block-request channels onto one hps_io SD port.
// One request in flight; sd_ack is routed back only to the granted channel.
module ieeedrv_sd_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 2**24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0][31:0] req_lba,
  input  logic [NREQ-1:0][5:0]  req_blk_cnt,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       req_err,
  input  logic [NREQ-1:0][7:0]  req_din,
  output logic [NREQ-1:0]       grant,
  ieeedrv_sd_arb_if.master      sd
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 25;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] g_idx;
  logic [CW-1:0] wait_cnt;

  logic          found;
  logic [IW-1:0] win;
  int unsigned   j;

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(rr) + i) % NREQ;
      if (!found && (req_rd[IW'(j)] || req_wr[IW'(j)])) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // hps_io data and ack only ever see the current owner; grant is zero outside REQ/XFER.
  always_comb begin
    sd.sd_buff_din = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sd.sd_buff_din = req_din[i];
    end
  end

  assign req_ack = grant & {NREQ{sd.sd_ack}};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      rr            <= '0;
      g_idx         <= '0;
      wait_cnt      <= '0;
      grant         <= '0;
      req_err       <= '0;
      sd.sd_lba     <= '0;
      sd.sd_blk_cnt <= '0;
      sd.sd_rd      <= 1'b0;
      sd.sd_wr      <= 1'b0;
    end else begin
      req_err <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state         <= REQ;
            g_idx         <= win;
            grant         <= NREQ'(1) << win;
            sd.sd_lba     <= req_lba[win];
            sd.sd_blk_cnt <= req_blk_cnt[win];
            // A simultaneous read stays pending and wins a later grant.
            sd.sd_wr      <= req_wr[win];
            sd.sd_rd      <= req_rd[win] & ~req_wr[win];
            wait_cnt      <= '0;
          end
        end
        REQ: begin
          if (sd.sd_ack) begin
            state    <= XFER;
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
          end else if (!(req_rd[g_idx] || req_wr[g_idx])) begin
            state    <= IDLE;
            grant    <= '0;
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
          end else if (wait_cnt >= TO_CNT) begin
            state          <= IDLE;
            grant          <= '0;
            req_err[g_idx] <= 1'b1;
            sd.sd_rd       <= 1'b0;
            sd.sd_wr       <= 1'b0;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        XFER: begin
          if (!sd.sd_ack) begin
            state <= IDLE;
            grant <= '0;
            rr    <= (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + IW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          sd.sd_rd <= 1'b0;
          sd.sd_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Directed bench for ieeedrv_sd_arb: NREQ=2, TIMEOUT shortened to 100 cycles.
module tb_ieeedrv_sd_arb;
  localparam int unsigned NREQ = 2;

  logic                  clk_sys = 1'b0;
  logic                  reset;
  logic [NREQ-1:0][31:0] req_lba;
  logic [NREQ-1:0][5:0]  req_blk_cnt;
  logic [NREQ-1:0]       req_rd;
  logic [NREQ-1:0]       req_wr;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       req_err;
  logic [NREQ-1:0][7:0]  req_din;
  logic [NREQ-1:0]       grant;

  int n_assert = 0;
  int n_fail   = 0;

  ieeedrv_sd_arb_if sd ();

  ieeedrv_sd_arb #(.NREQ(NREQ), .TIMEOUT(100)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_lba     (req_lba),
    .req_blk_cnt (req_blk_cnt),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .req_err     (req_err),
    .req_din     (req_din),
    .grant       (grant),
    .sd          (sd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a grant, check it, run a 4-cycle ack burst, release the channel's request.
  task automatic serve(input string tag, input logic [1:0] exp_g, input logic exp_wr,
                       input logic keep_rd);
    int n = 0;
    int ch;
    while (grant == '0 && n < 8) begin
      tick();
      n++;
    end
    ch = exp_g[1] ? 1 : 0;
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    chk({tag, "_sd_wr"}, 32'(sd.sd_wr), 32'(exp_wr));
    chk({tag, "_sd_rd"}, 32'(sd.sd_rd), 32'(!exp_wr));
    sd.sd_ack = 1'b1;
    #1;
    chk({tag, "_ack_on"}, 32'(req_ack), 32'(exp_g));
    tick();
    chk({tag, "_op_drop"}, 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
    req_wr[ch] = 1'b0;
    if (!keep_rd) req_rd[ch] = 1'b0;
    repeat (3) tick();
    sd.sd_ack = 1'b0;
    #1;
    chk({tag, "_ack_off"}, 32'(req_ack), 32'd0);
    tick();
    chk({tag, "_release"}, 32'(grant), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    req_lba     = '0;
    req_blk_cnt = '0;
    req_rd      = '0;
    req_wr      = '0;
    req_din     = '0;
    sd.sd_ack   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sd_lba", sd.sd_lba, 32'd0);
    chk("rst_op", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
    chk("rst_ack_err", 32'({req_ack, req_err}), 32'd0);
    chk("rst_din", 32'(sd.sd_buff_din), 32'd0);

    // single read on ch0, lba 357, ack cycles 6..25
    req_rd[0]      = 1'b1;
    req_lba[0]     = 32'd357;
    req_blk_cnt[0] = 6'd3;
    req_din[0]     = 8'hA5;
    req_din[1]     = 8'h3C;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_sd_rd", 32'(sd.sd_rd), 32'd1);
    chk("t1_sd_lba", sd.sd_lba, 32'd357);
    chk("t1_blk", 32'(sd.sd_blk_cnt), 32'd3);
    chk("t1_din", 32'(sd.sd_buff_din), 32'hA5);
    chk("t1_ack_pre", 32'(req_ack), 32'd0);
    req_lba[0] = 32'd999;
    repeat (5) tick();
    chk("t1_sd_rd_c6", 32'(sd.sd_rd), 32'd1);
    chk("t1_lba_hold", sd.sd_lba, 32'd357);
    sd.sd_ack = 1'b1;
    #1;
    chk("t1_ack_c6", 32'(req_ack), 32'h1);
    tick();
    chk("t1_sd_rd_c7", 32'(sd.sd_rd), 32'd0);
    chk("t1_ack_c7", 32'(req_ack), 32'h1);
    chk("t1_grant_c7", 32'(grant), 32'h1);
    req_rd[0] = 1'b0;
    repeat (18) tick();
    chk("t1_ack_c25", 32'(req_ack), 32'h1);
    sd.sd_ack = 1'b0;
    #1;
    chk("t1_ack_fall", 32'(req_ack), 32'd0);
    tick();
    chk("t1_grant_end", 32'(grant), 32'd0);
    chk("t1_din_idle", 32'(sd.sd_buff_din), 32'd0);

    // round robin from rr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    req_rd = 2'b11;
    serve("rr_a0", 2'b01, 1'b0, 1'b0);
    serve("rr_a1", 2'b10, 1'b0, 1'b0);
    req_rd = 2'b11;
    serve("rr_b0", 2'b01, 1'b0, 1'b0);
    serve("rr_b1", 2'b10, 1'b0, 1'b0);

    // read+write together on ch1: write first, read on a later grant
    req_rd[1] = 1'b1;
    req_wr[1] = 1'b1;
    serve("rw_wr", 2'b10, 1'b1, 1'b1);
    serve("rw_rd", 2'b10, 1'b0, 1'b0);

    // stale sd_ack in IDLE
    sd.sd_ack = 1'b1;
    repeat (2) tick();
    chk("stale_grant", 32'(grant), 32'd0);
    chk("stale_ack", 32'(req_ack), 32'd0);
    sd.sd_ack = 1'b0;
    tick();

    // timeout on ch0 write
    req_wr[0] = 1'b1;
    tick();
    chk("to_grant", 32'(grant), 32'h1);
    chk("to_sd_wr", 32'(sd.sd_wr), 32'd1);
    repeat (100) tick();
    chk("to_err_c100", 32'(req_err), 32'd0);
    chk("to_wr_c100", 32'(sd.sd_wr), 32'd1);
    tick();
    chk("to_err_c101", 32'(req_err), 32'h1);
    chk("to_wr_c101", 32'(sd.sd_wr), 32'd0);
    chk("to_grant_c101", 32'(grant), 32'd0);
    req_wr[0] = 1'b0;
    tick();
    chk("to_err_c102", 32'(req_err), 32'd0);

    // cancel: ch0 drops read before ack, ch1 then granted
    req_rd[0] = 1'b1;
    tick();
    chk("cx_grant0", 32'(grant), 32'h1);
    req_rd[1] = 1'b1;
    tick();
    req_rd[0] = 1'b0;
    tick();
    chk("cx_sd_rd", 32'(sd.sd_rd), 32'd0);
    chk("cx_grant_off", 32'(grant), 32'd0);
    chk("cx_ack", 32'(req_ack), 32'd0);
    tick();
    chk("cx_grant1", 32'(grant), 32'h2);
    serve("cx_ch1", 2'b10, 1'b0, 1'b0);

    // reset while in XFER with sd_ack high
    req_rd[0] = 1'b1;
    tick();
    sd.sd_ack = 1'b1;
    tick();
    chk("rx_ack_pre", 32'(req_ack), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_grant", 32'(grant), 32'd0);
    chk("rx_op", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
    chk("rx_ack", 32'(req_ack), 32'd0);
    chk("rx_err", 32'(req_err), 32'd0);
    req_rd[0] = 1'b0;
    sd.sd_ack = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
